// File: rtl/result_unloader_pkg.sv
// Shared definitions for the result unloader.
//   - Default matrix dimensions, so the top-level controller and the
//     unloader agree on element width and result shape.
//   - FSM state encoding (IDLE / PRIME / STREAM, 2 bits).
//   - width_of(): counter/index width helper that never returns zero, so
//     degenerate 1-row or 1-column shapes still get a legal 1-bit field.
package result_unloader_pkg;

    localparam int DEF_BIT_W = 16;
    localparam int DEF_ROWS  = 3;
    localparam int DEF_COLS  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PRIME  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_unloader_if.sv
// Output stream of the result unloader: one matrix element per beat over a
// valid/ready handshake, tagged with its row/column and a last flag.
//   out_data   element value
//   out_valid  out_data is valid
//   out_ready  sink accepts the current element
//   out_last   current element is the final one of the matrix
//   out_row    row of the current element
//   out_col    column of the current element
// master = the unloader (source), slave = the sink.
interface result_unloader_if #(
    parameter int BIT_W = 16,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
);
    logic [BIT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;

    modport master (
        output out_data, out_valid, out_last, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: owns the result matrix buffer and streams it out.
// The store phase writes elements by linear address (row*COLS+col) while the
// unit is idle; on start the whole matrix is emitted in row-major order over
// the valid/ready stream, and done pulses once the final element is taken.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   wr_en/addr/data  element write port (honoured only while idle)
//   start         begin streaming (sampled only while idle)
//   out           stream master (data/valid/ready/last/row/col)
//   busy          high while priming or streaming
//   done          one-cycle pulse after the final handshake
module result_unloader
    import result_unloader_pkg::*;
#(
    parameter int BIT_W = DEF_BIT_W,
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DEPTH = ROWS * COLS,
    parameter int AW    = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BIT_W-1:0] wr_data,
    input  logic             start,
    result_unloader_if.master out,
    output logic             busy,
    output logic             done
);

    localparam int ROW_W = width_of(ROWS);
    localparam int COL_W = width_of(COLS);

    // Element storage; not cleared by reset, read asynchronously.
    logic [BIT_W-1:0] mem [DEPTH];

    state_t           state_reg;
    logic [AW-1:0]    idx_reg;
    logic [BIT_W-1:0] data_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             done_reg;
    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;

    logic             wr_ok;
    logic             handshake;
    logic [AW-1:0]    idx_next;
    logic             last_next;

    // Writes only land while idle and in range; anything addressed past the
    // matrix is silently ignored so it cannot alias onto a real element.
    assign wr_ok = wr_en && (state_reg == ST_IDLE)
                   && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign handshake = valid_reg && out.out_ready;
    assign idx_next  = idx_reg + 1'b1;
    assign last_next = (idx_next == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_PRIME;
                        idx_reg   <= '0;
                    end
                end
                ST_PRIME: begin
                    data_reg  <= mem[0];
                    row_reg   <= '0;
                    col_reg   <= '0;
                    valid_reg <= 1'b1;
                    last_reg  <= (DEPTH == 1);
                    state_reg <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Without a handshake every output register simply
                    // holds, which gives the stall behaviour for free.
                    if (handshake) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg  <= idx_next;
                            data_reg <= mem[idx_next];
                            last_reg <= last_next;
                            // Incremental row/col tracking avoids a divider.
                            if (col_reg == COL_W'(COLS - 1)) begin
                                col_reg <= '0;
                                row_reg <= row_reg + 1'b1;
                            end else begin
                                col_reg <= col_reg + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out.out_data  = data_reg;
    assign out.out_valid = valid_reg;
    assign out.out_last  = last_reg;
    assign out.out_row   = row_reg;
    assign out.out_col   = col_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;

endmodule

// File: tb/tb_result_unloader.sv
// Directed testbench for result_unloader: a 3x3 instance for the main
// scenarios plus a 1x1 instance for the single-element corner case.
module tb_result_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;

    logic        w1_en;
    logic [0:0]  w1_addr;
    logic [15:0] w1_data;
    logic        start1;
    logic        busy1;
    logic        done1;

    int n_cmp  = 0;
    int n_fail = 0;

    result_unloader_if #(.BIT_W(16), .ROW_W(2), .COL_W(2)) bus ();
    result_unloader_if #(.BIT_W(16), .ROW_W(1), .COL_W(1)) bus1 ();

    result_unloader #(.BIT_W(16), .ROWS(3), .COLS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .out     (bus),
        .busy    (busy),
        .done    (done)
    );

    result_unloader #(.BIT_W(16), .ROWS(1), .COLS(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w1_en),
        .wr_addr (w1_addr),
        .wr_data (w1_data),
        .start   (start1),
        .out     (bus1),
        .busy    (busy1),
        .done    (done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_done;
    } vec_t;

    vec_t tbl [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write3(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Checks the nine elements of a 3x3 stream (ready held high), then the
    // done cycle. Optionally sprays 0xFFFF writes or pokes start mid-stream.
    task automatic elems(input string tag, input bit junk, input bit poke);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (junk) begin
                wr_en   = 1'b1;
                wr_addr = 4'(k);
                wr_data = 16'hFFFF;
            end
            start = poke && (k == 3);
            check($sformatf("%s valid[%0d]", tag, k), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s data[%0d]", tag, k), 32'(bus.out_data), 32'(k + 1));
            check($sformatf("%s row[%0d]", tag, k), 32'(bus.out_row), 32'(k / 3));
            check($sformatf("%s col[%0d]", tag, k), 32'(bus.out_col), 32'(k % 3));
            check($sformatf("%s last[%0d]", tag, k), 32'(bus.out_last), 32'(k == 8));
            check($sformatf("%s done[%0d]", tag, k), 32'(done), 32'd0);
            check($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'd1);
            $display("%s: element %0d data=%0d row=%0d col=%0d last=%0b",
                     tag, k, bus.out_data, bus.out_row, bus.out_col, bus.out_last);
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " valid end"}, 32'(bus.out_valid), 32'd0);
        check({tag, " last end"}, 32'(bus.out_last), 32'd0);
    endtask

    task automatic stream3(input string tag, input bit junk, input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " prime busy"}, 32'(busy), 32'd1);
        check({tag, " prime valid"}, 32'(bus.out_valid), 32'd0);
        if (junk) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_data = 16'hFFFF;
        end
        tick();
        elems(tag, junk, poke);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0; start1 = 1'b0;
        bus.out_ready = 1'b0; bus1.out_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst valid", 32'(bus.out_valid), 32'd0);
        check("rst data", 32'(bus.out_data), 32'd0);
        check("rst last", 32'(bus.out_last), 32'd0);
        check("rst row", 32'(bus.out_row), 32'd0);
        check("rst col", 32'(bus.out_col), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        // Fill buf[k] = k+1, then out-of-range writes that must be ignored
        for (int k = 0; k < 9; k++) write3(4'(k), 16'(k + 1));
        for (int a = 9; a < 16; a++) write3(4'(a), 16'hDEAD);

        // Basic stream with ready held high
        stream3("basic", 1'b0, 1'b0);
        tick();
        check("basic done clears", 32'(done), 32'd0);

        // Stall pattern: ready 1,0,0,1 repeating
        tbl[0]  = '{1'b1, 1'b1, 16'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'd5, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'd6, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 16'd6, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'd6, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 16'd7, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'd8, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 16'd8, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 16'd8, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 16'd9, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
        bus.out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick();
        hs = 0;
        for (int i = 0; i < 18; i++) begin
            bus.out_ready = tbl[i].ready;
            check($sformatf("stall valid[%0d]", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("stall done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
            if (tbl[i].exp_valid) begin
                check($sformatf("stall data[%0d]", i), 32'(bus.out_data), 32'(tbl[i].exp_data));
                check($sformatf("stall last[%0d]", i), 32'(bus.out_last), 32'(tbl[i].exp_last));
                check($sformatf("stall row[%0d]", i), 32'(bus.out_row), 32'((tbl[i].exp_data - 1) / 3));
                check($sformatf("stall col[%0d]", i), 32'(bus.out_col), 32'((tbl[i].exp_data - 1) % 3));
            end
            if (bus.out_valid && bus.out_ready) begin
                hs++;
                $display("stall: cycle %0d handshake data=%0d", i, bus.out_data);
            end
            tick();
        end
        check("stall handshakes", 32'(hs), 32'd9);

        // Writes during PRIME/STREAM are dropped; rerun clean to confirm
        stream3("junk", 1'b1, 1'b0);
        tick();
        stream3("after-junk", 1'b0, 1'b0);
        tick();

        // Reset after the 4th handshake
        bus.out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int k = 0; k < 4; k++) begin
            $display("abort: element %0d data=%0d", k, bus.out_data);
            tick();
        end
        check("abort pre data", 32'(bus.out_data), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort data", 32'(bus.out_data), 32'd0);
        check("abort row", 32'(bus.out_row), 32'd0);
        tick();
        check("abort no done", 32'(done), 32'd0);
        stream3("restart", 1'b0, 1'b0);

        // start poked mid-stream is ignored; start in the done cycle restarts
        tick();
        stream3("poke", 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("back2back prime busy", 32'(busy), 32'd1);
        check("back2back prime valid", 32'(bus.out_valid), 32'd0);
        check("back2back prime done", 32'(done), 32'd0);
        tick();
        elems("back2back", 1'b0, 1'b0);
        tick();

        // 1x1 instance
        w1_en = 1'b1; w1_addr = 1'b1; w1_data = 16'h5555; tick();
        w1_addr = 1'b0; w1_data = 16'h00AB; tick();
        w1_en = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("1x1 prime busy", 32'(busy1), 32'd1);
        check("1x1 prime valid", 32'(bus1.out_valid), 32'd0);
        tick();
        check("1x1 valid", 32'(bus1.out_valid), 32'd1);
        check("1x1 last", 32'(bus1.out_last), 32'd1);
        check("1x1 data", 32'(bus1.out_data), 32'h00AB);
        check("1x1 row", 32'(bus1.out_row), 32'd0);
        check("1x1 col", 32'(bus1.out_col), 32'd0);
        check("1x1 done early", 32'(done1), 32'd0);
        $display("1x1: element 0 data=%0h last=%0b", bus1.out_data, bus1.out_last);
        bus1.out_ready = 1'b1;
        tick();
        check("1x1 done", 32'(done1), 32'd1);
        check("1x1 busy end", 32'(busy1), 32'd0);
        check("1x1 valid end", 32'(bus1.out_valid), 32'd0);
        tick();
        check("1x1 done clears", 32'(done1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
# result_unloader

Owns the accelerator's result matrix buffer and streams it out of the core. The compute/store phase writes elements into it by address. On `start`, it emits all `ROWS*COLS` elements in row-major order over a valid/ready handshake. It is the output-side counterpart of the serial `inp_a`/`inp_b` load path in the top-level controller, and it pulses `done` when the last element has been accepted.

## Interface
Parameters:
- `BIT_W`, 16, element width; matches the top-level `BIT_W`.
- `ROWS`, 3, result rows (`A_M`).
- `COLS`, 3, result columns (`B_N`).
- `DEPTH`, `ROWS*COLS`, derived; do not override.
- `AW`, `$clog2(DEPTH)`, derived address width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  write strobe from store phase.
- `wr_addr`  in  AW  element index, `row*COLS+col`.
- `wr_data`  in  BIT_W  element value.
- `start`  in  1  begin streaming; sampled only in IDLE.
- `out_data`  out  BIT_W  current element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts.
- `out_last`  out  1  current element is index `DEPTH-1`.
- `out_row`  out  `$clog2(ROWS)`  row of current element.
- `out_col`  out  `$clog2(COLS)`  column of current element.
- `busy`  out  1  high in PRIME/STREAM.
- `done`  out  1  one-cycle pulse after final handshake.

## Operation
- Storage: `DEPTH` x `BIT_W` register array with asynchronous read. Contents are not cleared by reset.
- Writes:
  - Accepted only in IDLE when `wr_en` is high and `wr_addr < DEPTH`.
  - Out-of-range addresses are ignored.
  - Writes in PRIME/STREAM are dropped.
- States:
  - IDLE: outputs idle. `start` → PRIME, with read index `idx` cleared to 0.
  - PRIME: registers `buf[0]` into `out_data`, sets `out_row`/`out_col` to 0/0, `out_valid`=1, `out_last`=(DEPTH==1); → STREAM.
  - STREAM: a handshake occurs when `out_valid && out_ready`.
    - On a handshake that is not the last element: `idx`++, `out_data`←`buf[idx+1]`, row/col advance (col wraps at `COLS-1` to 0 with row+1), `out_last` recomputed.
    - On a handshake of the last element: `out_valid`←0, `done`←1 for one cycle, → IDLE.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable. `out_valid` never drops before its handshake.
- `start` in PRIME/STREAM is ignored. `start` in the same cycle as the `done` pulse (state already IDLE) is accepted.
- A write in the same cycle as `start` is accepted; `start` takes effect next cycle.
- Reset mid-stream: the next cycle is IDLE, and all outputs take their reset values. A partial stream is abandoned, with no `done`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `out_row`=0, `out_col`=0, `busy`=0, `done`=0, state=IDLE, `idx`=0.
- Write-to-readable: 1 cycle. Data written at edge t is visible to a PRIME at t+1.
- `start` sampled at edge t0: PRIME during t0..t0+1, and `out_valid` is high from t0+2.
- With `out_ready` held high: element k is accepted at edge t0+2+k. `done` is high for the cycle after edge t0+2+DEPTH-1, and `busy` falls in the same cycle.
- Throughput: one element per cycle, with no bubbles between elements.
- `out_last` is coincident with element `DEPTH-1` only.

## Structure
- Shared package:
  - State encoding (IDLE/PRIME/STREAM, 2-bit).
  - Default dimension constants `BIT_W`, `ROWS`, `COLS`, so they are shared with the top-level controller.
- Single module; the row/column tracker is kept inline. No sub-module is needed: row/col are maintained incrementally, with no divider.

## Test plan
- Write `buf[k]=k+1` for k=0..8 (3x3), `start`, `out_ready`=1 → outputs 1..9 in order; row/col (0,0)..(2,2); `out_last` only on 9; `done` one cycle later.
- Same fill, toggle `out_ready` 1,0,0,1 repeating → each element held stable during stalls; 9 handshakes total; no duplicates or drops.
- `wr_en` with `wr_addr`=9..15 in IDLE → no corruption of `buf[0..8]`. Writes of 0xFFFF during STREAM → the streamed values are unchanged.
- Assert `rst` after the 4th handshake → next cycle `out_valid`=0, `busy`=0, no `done`. A restart then streams from element 0.
- `start` pulsed during STREAM → ignored. Second `start` asserted in the `done` cycle → a second full stream begins with `out_valid` two cycles later.
- `ROWS`=1, `COLS`=1 → single element with `out_last`=1 on its first valid cycle; `done` after one handshake.
